core_ifetch_pf: RTL and testbench

Prefetching instruction-fetch unit for the RV32I core, the next generation of the single-request fetch unit.
- Issues sequential AXI4-Lite reads on the IMEM read channels, with up to MAX_OUTSTANDING requests in flight.
- Buffers returned words with their PC and fault flag in a FIFO_DEPTH-entry queue.
- Presents instructions to the control unit over a valid/ready handshake.
- A redirect input (taken branch, jal, jalr) flushes the queue and drops stale in-flight responses, so the core no longer stalls one full AXI round trip per instruction.

---
 rtl/core_ifetch_pf_pkg.sv | 30 +++
 rtl/core_sync_fifo.sv | 60 ++++++
 rtl/core_ifetch_pf.sv | 170 +++++++++++++++++
 tb/tb_core_ifetch_pf.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_ifetch_pf_pkg.sv
// Shared types for the prefetching fetch unit: AXI response codes,
// instruction queue entry layout and PC helpers.
package core_ifetch_pf_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

  localparam int          ILEN   = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  localparam int ENT_FAULT = 0;
  localparam int ENT_PC    = 1;
  localparam int ENT_DATA  = 33;
  localparam int ENT_W     = 65;

  typedef struct packed {
    logic [ILEN-1:0] data;
    logic [31:0]     pc;
    logic            fault;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/core_sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; shared by the
// fetch and data-memory units. DEPTH must be a power of two.
module core_sync_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (do_pop) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/core_ifetch_pf.sv
// Prefetching instruction fetch unit (AXI4-Lite read side).
// Define CORE_IFETCH_FAULT_HALT_EN to stop issuing after a faulting fetch.
module core_ifetch_pf
  import core_ifetch_pf_pkg::*;
#(
  parameter int          AXI_AWIDTH      = 32,
  parameter int          AXI_DWIDTH      = 32,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic                  CLK,
  input  logic                  NRST,
  output logic [AXI_AWIDTH-1:0] AXI_ARADDR,
  output logic                  AXI_ARVALID,
  input  logic                  AXI_ARREADY,
  input  logic [AXI_DWIDTH-1:0] AXI_RDATA,
  input  logic [1:0]            AXI_RRESP,
  input  logic                  AXI_RVALID,
  output logic                  AXI_RREADY,
  input  logic                  REDIRECT,
  input  logic [31:0]           REDIRECT_PC,
  output logic                  INSTR_VALID,
  input  logic                  INSTR_READY,
  output logic [31:0]           INSTRUCTION,
  output logic [31:0]           INSTR_PC,
  output logic                  INSTR_FAULT,
  output logic                  BUSY
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   araddr_q, araddr_d;
  logic          arv_q, arv_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] disc_q, disc_d;

  logic          ar_hs;
  logic          ar_stall;
  logic          r_hs;
  logic          push;
  logic          pop;
  logic          credit;
  logic [CW-1:0] out_after;
  logic [CW-1:0] cnt_nxt;

  fetch_entry_t     push_ent;
  logic [ENT_W-1:0] head;
  logic             q_full;
  logic             q_empty;
  logic [CW-1:0]    q_cnt;

  assign ar_hs    = arv_q & AXI_ARREADY;
  assign ar_stall = arv_q & ~AXI_ARREADY;
  assign r_hs     = AXI_RVALID & (out_q != '0);
  assign push     = r_hs & ~REDIRECT & (disc_q == '0) & ~q_full;
  assign pop      = INSTR_VALID & INSTR_READY;

  assign push_ent = '{
    data:  AXI_RDATA[ILEN-1:0],
    pc:    resp_pc_q,
    fault: (AXI_RRESP != RESP_OKAY)
  };

  assign out_after = out_q + CW'(ar_hs) - CW'(r_hs);
  assign cnt_nxt   = REDIRECT ? '0 : q_cnt + CW'(push) - CW'(pop);
  assign credit    = (out_after < MAX_C) &&
                     (({1'b0, out_after} + {1'b0, cnt_nxt}) < DEPTH_C);

`ifdef CORE_IFETCH_FAULT_HALT_EN
  logic halt_q, halt_d;

  always_comb begin
    halt_d = halt_q;
    if (REDIRECT) begin
      halt_d = 1'b0;
    end else if (push && push_ent.fault) begin
      halt_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`else
  logic halt_d;
  assign halt_d = 1'b0;
`endif

  // fetch_pc names the next address to be armed; a stalled AR keeps
  // its own latched address so a redirect cannot alter it
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    araddr_d   = araddr_q;
    disc_d     = disc_q;
    out_d      = out_after;
    arv_d      = ar_stall;
    if (REDIRECT) begin
      fetch_pc_d = align_pc(REDIRECT_PC);
      resp_pc_d  = align_pc(REDIRECT_PC);
      disc_d     = out_after + CW'(ar_stall);
    end else if (r_hs) begin
      if (disc_q != '0) begin
        disc_d = disc_q - CW'(1);
      end else begin
        resp_pc_d = resp_pc_q + PC_INC;
      end
    end
    if (!ar_stall && credit && !halt_d) begin
      arv_d      = 1'b1;
      araddr_d   = fetch_pc_d;
      fetch_pc_d = fetch_pc_d + PC_INC;
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      araddr_q   <= RESET_PC;
      arv_q      <= 1'b0;
      out_q      <= '0;
      disc_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      araddr_q   <= araddr_d;
      arv_q      <= arv_d;
      out_q      <= out_d;
      disc_q     <= disc_d;
    end
  end

  core_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk     (CLK),
    .rst_n   (NRST),
    .push_i  (push),
    .data_i  (push_ent),
    .pop_i   (pop),
    .flush_i (REDIRECT),
    .data_o  (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_cnt)
  );

  assign AXI_ARADDR  = AXI_AWIDTH'(araddr_q);
  assign AXI_ARVALID = arv_q;
  assign AXI_RREADY  = 1'b1;

  assign INSTR_VALID = ~q_empty;
  assign INSTRUCTION = head[ENT_DATA +: ILEN];
  assign INSTR_PC    = head[ENT_PC +: 32];
  assign INSTR_FAULT = head[ENT_FAULT];

  assign BUSY = (out_q != '0) | arv_q | (disc_q != '0);

endmodule

// File: tb/tb_core_ifetch_pf.sv
// Randomized bench for core_ifetch_pf: AXI slave model plus an
// in-order instruction stream reference that restarts on redirect.
module tb_core_ifetch_pf;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic        CLK = 1'b0;
  logic        NRST;
  logic [31:0] ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTRUCTION;
  logic [31:0] INSTR_PC;
  logic        INSTR_FAULT;
  logic        BUSY;

  always #5 CLK = ~CLK;

  core_ifetch_pf #(
    .AXI_AWIDTH      (32),
    .AXI_DWIDTH      (32),
    .FIFO_DEPTH      (DEPTH),
    .MAX_OUTSTANDING (MAXO),
    .RESET_PC        (32'h0)
  ) dut (
    .CLK         (CLK),
    .NRST        (NRST),
    .AXI_ARADDR  (ARADDR),
    .AXI_ARVALID (ARVALID),
    .AXI_ARREADY (ARREADY),
    .AXI_RDATA   (RDATA),
    .AXI_RRESP   (RRESP),
    .AXI_RVALID  (RVALID),
    .AXI_RREADY  (RREADY),
    .REDIRECT    (REDIRECT),
    .REDIRECT_PC (REDIRECT_PC),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .INSTRUCTION (INSTRUCTION),
    .INSTR_PC    (INSTR_PC),
    .INSTR_FAULT (INSTR_FAULT),
    .BUSY        (BUSY)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [31:0] bad_addr;
  bit          faults_on;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  function automatic bit is_bad(input logic [31:0] a);
    return (a == bad_addr) || (faults_on && a[6:2] == 5'd19);
  endfunction

  logic [31:0] rq[$];
  logic [31:0] ar_log[$];
  int          p_ar, p_r, p_rdy;
  bit          do_redir;
  logic [31:0] redir_pc;
  logic [31:0] exp_pc;
  logic [31:0] exp_ar;
  bit          chk_ar;
  int          pops, ar_cnt, inflight, saw_fault;
  logic [31:0] last_ar;
  bit          prev_stall;
  logic [31:0] prev_addr;

  task automatic step();
    logic [31:0] a;
    @(negedge CLK);
    if (prev_stall) begin
      chk("ar_hold_valid", ARVALID, 1);
      chk("ar_hold_addr", ARADDR, prev_addr);
    end
    if (rq.size() > 0 && $urandom_range(99) < p_r) begin
      a = rq.pop_front();
      RVALID = 1'b1;
      RDATA  = mem_word(a);
      RRESP  = is_bad(a) ? 2'b10 : 2'b00;
      inflight--;
    end else begin
      RVALID = 1'b0;
      RDATA  = $urandom;
      RRESP  = 2'b00;
    end
    ARREADY = ($urandom_range(99) < p_ar);
    if (ARVALID && ARREADY) begin
      rq.push_back(ARADDR);
      ar_log.push_back(ARADDR);
      ar_cnt++;
      last_ar = ARADDR;
      inflight++;
      chk("inflight_max", 32'(inflight <= MAXO), 1);
      if (chk_ar) begin
        chk("araddr", ARADDR, exp_ar);
        exp_ar += 4;
      end
    end
    prev_stall = ARVALID && !ARREADY;
    prev_addr  = ARADDR;
    INSTR_READY = ($urandom_range(99) < p_rdy);
    REDIRECT    = do_redir;
    REDIRECT_PC = redir_pc;
    do_redir    = 1'b0;
    if (INSTR_VALID && INSTR_READY && !REDIRECT) begin
      chk("instr_pc", INSTR_PC, exp_pc);
      chk("instr_data", INSTRUCTION, mem_word(exp_pc));
      chk("instr_fault", INSTR_FAULT, 32'(is_bad(exp_pc)));
      if (INSTR_FAULT) saw_fault++;
      exp_pc += 4;
      pops++;
    end
    if (REDIRECT) exp_pc = {redir_pc[31:2], 2'b00};
  endtask

  task automatic do_reset();
    NRST = 1'b0;
    ARREADY = 1'b0; RVALID = 1'b0; RDATA = '0; RRESP = '0;
    REDIRECT = 1'b0; REDIRECT_PC = '0; INSTR_READY = 1'b0;
    rq.delete(); ar_log.delete();
    inflight = 0; prev_stall = 1'b0; exp_pc = '0; exp_ar = '0;
    pops = 0; ar_cnt = 0; last_ar = '0; saw_fault = 0;
    chk_ar = 1'b0; do_redir = 1'b0; redir_pc = '0;
    bad_addr = 32'hFFFF_FFFF; faults_on = 1'b0;
    p_ar = 100; p_r = 100; p_rdy = 100;
    repeat (2) @(negedge CLK);
    NRST = 1'b1;
  endtask

  initial begin
    do_reset();
    NRST = 1'b0;
    #1;
    chk("rst_arvalid", ARVALID, 0);
    chk("rst_rready", RREADY, 1);
    chk("rst_ivalid", INSTR_VALID, 0);
    chk("rst_instr", INSTRUCTION, 0);
    chk("rst_pc", INSTR_PC, 0);
    chk("rst_fault", INSTR_FAULT, 0);
    chk("rst_busy", BUSY, 0);

    // sustained sequential fetch
    do_reset();
    chk_ar = 1'b1;
    repeat (40) step();
    chk("seq_rate", 32'(pops >= 36), 1);

    // consumer back-pressure fills the queue exactly
    do_reset();
    chk_ar = 1'b1;
    p_rdy = 0;
    repeat (20) step();
    chk("bp_ar_cnt", ar_cnt, DEPTH);
    chk("bp_last_ar", last_ar, 32'hC);
    chk("bp_arvalid", ARVALID, 0);
    chk("bp_busy", BUSY, 0);
    p_rdy = 100;
    repeat (20) step();
    chk("bp_resume", 32'(pops >= 15), 1);

    // redirect with two reads in flight
    do_reset();
    p_r = 0;
    for (int i = 0; i < 10 && ar_cnt < 2; i++) step();
    chk("rd_inflight", ar_cnt, 2);
    redir_pc = 32'h103; do_redir = 1'b1;
    step();
    p_r = 100; chk_ar = 1'b1; exp_ar = 32'h100;
    repeat (15) step();
    chk("rd_pops", 32'(pops >= 5), 1);

    // redirect while an AR is stalled
    do_reset();
    for (int i = 0; i < 10 && ar_cnt < 2; i++) step();
    p_ar = 0;
    repeat (2) step();
    chk("st_arvalid", ARVALID, 1);
    chk("st_araddr", ARADDR, 32'h8);
    redir_pc = 32'h40; do_redir = 1'b1;
    repeat (3) step();
    chk("st_hold", ARADDR, 32'h8);
    p_ar = 100;
    repeat (15) step();
    chk("st_ar2", ar_log.size() > 3 ? ar_log[2] : 32'hDEAD_BEEF, 32'h8);
    chk("st_ar3", ar_log.size() > 3 ? ar_log[3] : 32'hDEAD_BEEF, 32'h40);

    // faulting fetch
    do_reset();
    bad_addr = 32'h4;
    repeat (30) step();
    chk("flt_seen", saw_fault, 1);
`ifdef CORE_IFETCH_FAULT_HALT_EN
    chk("flt_last_ar", last_ar, 32'h8);
    chk("flt_arvalid", ARVALID, 0);
    chk("flt_busy", BUSY, 0);
    redir_pc = 32'h200; do_redir = 1'b1;
    repeat (10) step();
    chk("flt_resume", 32'(last_ar >= 32'h200), 1);
`else
    chk("flt_cont", 32'(ar_cnt >= 20), 1);
`endif

    // asynchronous reset mid-burst
    do_reset();
    repeat (10) step();
    #2 NRST = 1'b0;
    #1;
    chk("ar_rst_arvalid", ARVALID, 0);
    chk("ar_rst_ivalid", INSTR_VALID, 0);
    chk("ar_rst_busy", BUSY, 0);
    chk("ar_rst_pc", INSTR_PC, 0);
    do_reset();
    repeat (5) step();
    chk("post_rst_ar", ar_log.size() > 0 ? ar_log[0] : 32'hDEAD_BEEF, 0);

    // random traffic with redirects and faults
    do_reset();
    faults_on = 1'b1;
    p_ar = 70; p_r = 60; p_rdy = 70;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3) begin
        do_redir = 1'b1;
        redir_pc = $urandom & 32'h0000_0FFF;
      end
      step();
    end
    chk("rand_progress", 32'(pops > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
